// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide engine producing the HI/LO pair.
// Multiply is radix-2 Booth (SIGNED=1) or shift-add (SIGNED=0), one step per
// clock. Divide is restoring division on operand magnitudes, one quotient
// bit per clock, with a sign fix-up on the final step. A start is accepted
// only in IDLE. done pulses for one cycle per result. DivZero pulses together
// with done when the divisor is zero, and in that case HI/LO are left alone.
module mult_div_unit #(
   parameter int WIDTH  = 32,
   parameter bit SIGNED = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             MultCtrl,
   input  logic             DivCtrl,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             busy,
   output logic             done,
   output logic             DivZero
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

   state_t             state, state_nxt;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   mcand;      // multiplicand (MULT) or divisor magnitude (DIV)
   logic [2*WIDTH+1:0] prod;       // {U[W:0], Q[W-1:0], q_-1}
   logic [WIDTH-1:0]   rem, quo;
   logic               neg_q, neg_r;
   logic               last;

   logic [WIDTH:0]     m_ext, u_cur, u_sum, shifted, diff;
   logic [2*WIDTH+1:0] prod_nxt;
   logic [WIDTH-1:0]   rem_nxt, quo_nxt, q_fix, r_fix, a_mag, b_mag;

   // One multiply step, one divide step and the operand magnitudes.
   always_comb begin
      last    = (cnt == CW'(WIDTH - 1));
      m_ext   = SIGNED ? {mcand[WIDTH-1], mcand} : {1'b0, mcand};
      u_cur   = prod[2*WIDTH+1:WIDTH+1];
      u_sum   = u_cur;
      if (SIGNED) begin
         // Booth pair {Q[0], q_-1}: 01 adds, 10 subtracts, then arithmetic shift.
         case (prod[1:0])
            2'b01:   u_sum = u_cur + m_ext;
            2'b10:   u_sum = u_cur - m_ext;
            default: u_sum = u_cur;
         endcase
         prod_nxt = {u_sum[WIDTH], u_sum, prod[WIDTH:1]};
      end else begin
         // Shift-add: the extra U bit keeps the carry, then logical shift.
         if (prod[1]) u_sum = u_cur + m_ext;
         prod_nxt = {1'b0, u_sum, prod[WIDTH:1]};
      end

      shifted = {rem, quo[WIDTH-1]};
      diff    = shifted - {1'b0, mcand};
      if (!diff[WIDTH]) begin
         rem_nxt = diff[WIDTH-1:0];
         quo_nxt = {quo[WIDTH-2:0], 1'b1};
      end else begin
         rem_nxt = shifted[WIDTH-1:0];
         quo_nxt = {quo[WIDTH-2:0], 1'b0};
      end
      q_fix = neg_q ? (-quo_nxt) : quo_nxt;
      r_fix = neg_r ? (-rem_nxt) : rem_nxt;

      a_mag = (SIGNED && A[WIDTH-1]) ? (-A) : A;
      b_mag = (SIGNED && B[WIDTH-1]) ? (-B) : B;
   end

   // Control state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state selection; multiply wins when both starts are high.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (MultCtrl)     state_nxt = MULT;
            else if (DivCtrl) state_nxt = (B == '0) ? DONE : DIV;
         end
         MULT, DIV: if (last) state_nxt = DONE;
         DONE:      state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // busy is high while an iterative operation is in progress.
   always_comb begin
      busy = (state == MULT) || (state == DIV);
   end

   // Operand latch, iteration registers and result/flag outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt     <= '0;
         mcand   <= '0;
         prod    <= '0;
         rem     <= '0;
         quo     <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         HI      <= '0;
         LO      <= '0;
         done    <= 1'b0;
         DivZero <= 1'b0;
      end else begin
         done    <= 1'b0;
         DivZero <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (MultCtrl) begin
                  mcand <= A;
                  prod  <= {{(WIDTH+1){1'b0}}, B, 1'b0};
               end else if (DivCtrl) begin
                  if (B == '0) begin
                     done    <= 1'b1;
                     DivZero <= 1'b1;
                  end else begin
                     mcand <= b_mag;
                     quo   <= a_mag;
                     rem   <= '0;
                     neg_q <= SIGNED && (A[WIDTH-1] ^ B[WIDTH-1]);
                     neg_r <= SIGNED && A[WIDTH-1];
                  end
               end
            end
            MULT: begin
               prod <= prod_nxt;
               cnt  <= cnt + 1'b1;
               if (last) begin
                  {HI, LO} <= prod_nxt[2*WIDTH:1];
                  done     <= 1'b1;
               end
            end
            DIV: begin
               quo <= quo_nxt;
               rem <= rem_nxt;
               cnt <= cnt + 1'b1;
               if (last) begin
                  LO   <= q_fix;
                  HI   <= r_fix;
                  done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
